jtag_ir_param: RTL and testbench
================================

JTAG_IR_PARAM -- requirements
Module: jtag_ir_param

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 2: instruction register length in bits, minimum 2.
REQ-002 SHALL have parameter NUM_INST, default 3: number of legal opcodes, 0..NUM_INST-1, maximum 2^IR_WIDTH-1.
REQ-003 SHALL have parameter RESET_INST, default 1: opcode loaded at reset.
REQ-004 SHALL have parameter STRICT_LEN, default 1: if 1, updates that follow fewer than IR_WIDTH shifts are rejected.
REQ-005 SHALL have port TCLK, input, 1 bit: scan clock; all state changes on its rising edge.
REQ-006 SHALL have port TRST, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port tlr, input, 1 bit: TAP in Test-Logic-Reset; synchronous reset.
REQ-008 SHALL have ports captureir, shiftir and updateir, input, 1 bit each: TAP state qualifiers.
REQ-009 SHALL have port TDI, input, 1 bit: serial data in.
REQ-010 SHALL have port TDO, output, 1 bit: serial data out, equal to shreg[0].
REQ-011 SHALL have port tdo_en, output, 1 bit: equal to shiftir, combinational.
REQ-012 SHALL have port inst, output, IR_WIDTH bits: active instruction.
REQ-013 SHALL have port dec, output, NUM_INST+1 bits: one-hot decode of inst; bit NUM_INST means BYPASS.
REQ-014 SHALL have port upd_err, output, 1 bit: one-cycle pulse when an update is rejected or substituted.

Function
REQ-015 SHALL hold an IR_WIDTH-bit shift register shreg, an active register inst, and a saturating counter shift_cnt of width clog2(IR_WIDTH+1) with range 0..IR_WIDTH.
REQ-016 On a cycle with captureir=1, SHALL load shreg = {IR_WIDTH-2 zeros, 2'b01} and clear shift_cnt to 0.
REQ-017 On a cycle with shiftir=1 and captureir=0, SHALL set shreg = {TDI, shreg[IR_WIDTH-1:1]}, shifting LSB-first toward TDO, and increment shift_cnt, saturating at IR_WIDTH.
REQ-018 When shiftir=1, the TDO value presented during that cycle SHALL be the pre-shift shreg[0].
REQ-019 On a cycle with updateir=1, SHALL evaluate shreg and shift_cnt as they are at the start of the cycle, in parallel with any capture or shift in the same cycle.
REQ-020 Update with STRICT_LEN=1 and shift_cnt<IR_WIDTH: inst SHALL be unchanged and upd_err SHALL pulse for 1 cycle.
REQ-021 Update with shreg<NUM_INST: inst SHALL become shreg, with no error.
REQ-022 Update with shreg>=NUM_INST: inst SHALL become all-ones (BYPASS) and upd_err SHALL pulse.
REQ-023 inst SHALL change only on update, tlr or TRST; shifting SHALL never disturb inst.
REQ-024 dec SHALL be registered and SHALL change in the same cycle as inst: dec[inst]=1 for inst<NUM_INST, otherwise dec[NUM_INST]=1; exactly one bit SHALL always be set.
REQ-025 Priority SHALL be TRST > tlr > all other controls; captureir SHALL take priority over shiftir.
REQ-026 shift_cnt SHALL reach IR_WIDTH and stay there for shifts of any length; the last IR_WIDTH bits shifted in form the opcode.
REQ-027 If no control input is high, all state SHALL hold.

Reset
REQ-028 TRST=1 SHALL immediately force inst=RESET_INST, dec=onehot(RESET_INST), shreg=0, shift_cnt=0 and upd_err=0, independent of TCLK.
REQ-029 tlr=1 SHALL apply the same values as REQ-028 at the next rising edge of TCLK.
REQ-030 TRST asserted in the middle of a shift SHALL abandon the shift; after release, the next update SHALL be rejected by STRICT_LEN unless a new capture and full shift occur first.
REQ-031 Parameter checks SHALL fail elaboration if RESET_INST>=NUM_INST, NUM_INST>2^IR_WIDTH-1, or IR_WIDTH<2.

Verification
REQ-032 Bench SHALL use IR_WIDTH=4, NUM_INST=6, RESET_INST=1 and STRICT_LEN=1 unless stated otherwise.
REQ-033 Pulse TRST -> inst=0001, dec=0000010, TDO=0, upd_err=0.
REQ-034 Capture, then shift TDI 1,1,0,0 LSB-first (opcode 0011), then update -> TDO sequence 1,0,0,0; inst=0011; dec[3]=1; no upd_err.
REQ-035 Capture, shift 2 bits only, then update -> inst unchanged, upd_err high for exactly 1 cycle; repeat with STRICT_LEN=0 -> inst updated, no error.
REQ-036 Shift 6 bits 1,0,1,0,1,0 then update -> inst=0101 (last four bits); shift opcode 1001 then update -> inst=1111, dec[6]=1, upd_err pulses.
REQ-037 Assert tlr for 1 cycle after loading 0011 -> inst=0001 at the next edge; assert TRST asynchronously mid-shift -> immediate reset values, then a following update without a new full shift is rejected.

Source files
------------

// File: rtl/jtag_ir_param.sv
// rtl/jtag_ir_param.sv - parameterised JTAG instruction register with length and opcode checking
// Capture/shift/update IR with registered one-hot decode and a rejected-update pulse.
module jtag_ir_param #(
  parameter int IR_WIDTH   = 2,
  parameter int NUM_INST   = 3,
  parameter int RESET_INST = 1,
  parameter int STRICT_LEN = 1
) (
  input  logic                TCLK,
  input  logic                TRST,
  input  logic                tlr,
  input  logic                captureir,
  input  logic                shiftir,
  input  logic                updateir,
  input  logic                TDI,
  output logic                TDO,
  output logic                tdo_en,
  output logic [IR_WIDTH-1:0] inst,
  output logic [NUM_INST:0]   dec,
  output logic                upd_err
);

  localparam int CNT_W = $clog2(IR_WIDTH + 1);
  localparam logic [CNT_W-1:0]    FULL_CNT    = CNT_W'(IR_WIDTH);
  localparam logic [IR_WIDTH:0]   NUM_INST_W  = (IR_WIDTH + 1)'(NUM_INST);
  localparam logic [IR_WIDTH-1:0] RESET_VAL   = IR_WIDTH'(RESET_INST);
  localparam logic [IR_WIDTH-1:0] CAPTURE_VAL = {{(IR_WIDTH - 1){1'b0}}, 1'b1};
  localparam logic [IR_WIDTH-1:0] BYPASS_VAL  = {IR_WIDTH{1'b1}};

  if (IR_WIDTH < 2) begin : g_bad_ir_width
    $error("jtag_ir_param: IR_WIDTH must be at least 2");
  end
  if (NUM_INST > (2 ** IR_WIDTH) - 1) begin : g_bad_num_inst
    $error("jtag_ir_param: NUM_INST must leave room for the BYPASS opcode");
  end
  if (RESET_INST >= NUM_INST) begin : g_bad_reset_inst
    $error("jtag_ir_param: RESET_INST must be a legal opcode");
  end

  function automatic logic is_legal(input logic [IR_WIDTH-1:0] v);
    return {1'b0, v} < NUM_INST_W;
  endfunction

  // Any opcode outside 0..NUM_INST-1 decodes to the BYPASS bit.
  function automatic logic [NUM_INST:0] onehot(input logic [IR_WIDTH-1:0] v);
    logic [NUM_INST:0] r;
    r = '0;
    for (int i = 0; i < NUM_INST; i++) begin
      if (v == IR_WIDTH'(i)) r[i] = 1'b1;
    end
    if (!is_legal(v)) r[NUM_INST] = 1'b1;
    return r;
  endfunction

  logic [IR_WIDTH-1:0] shreg_q, shreg_d;
  logic [IR_WIDTH-1:0] inst_q, inst_d;
  logic [CNT_W-1:0]    shift_cnt_q, shift_cnt_d;
  logic [NUM_INST:0]   dec_q, dec_d;
  logic                upd_err_q, upd_err_d;

  always_comb begin
    shreg_d     = shreg_q;
    shift_cnt_d = shift_cnt_q;
    inst_d      = inst_q;
    dec_d       = dec_q;
    upd_err_d   = 1'b0;
    if (tlr) begin
      shreg_d     = '0;
      shift_cnt_d = '0;
      inst_d      = RESET_VAL;
      dec_d       = onehot(RESET_VAL);
    end else begin
      if (captureir) begin
        shreg_d     = CAPTURE_VAL;
        shift_cnt_d = '0;
      end else if (shiftir) begin
        shreg_d = {TDI, shreg_q[IR_WIDTH-1:1]};
        if (shift_cnt_q < FULL_CNT) shift_cnt_d = shift_cnt_q + CNT_W'(1);
      end
      // Update judges the pre-edge shreg/count, so a same-cycle shift does not leak in.
      if (updateir) begin
        if ((STRICT_LEN != 0) && (shift_cnt_q < FULL_CNT)) begin
          upd_err_d = 1'b1;
        end else if (is_legal(shreg_q)) begin
          inst_d = shreg_q;
          dec_d  = onehot(shreg_q);
        end else begin
          inst_d    = BYPASS_VAL;
          dec_d     = onehot(BYPASS_VAL);
          upd_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge TCLK or posedge TRST) begin
    if (TRST) begin
      shreg_q     <= '0;
      shift_cnt_q <= '0;
      inst_q      <= RESET_VAL;
      dec_q       <= onehot(RESET_VAL);
      upd_err_q   <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      shift_cnt_q <= shift_cnt_d;
      inst_q      <= inst_d;
      dec_q       <= dec_d;
      upd_err_q   <= upd_err_d;
    end
  end

  assign TDO     = shreg_q[0];
  assign tdo_en  = shiftir;
  assign inst    = inst_q;
  assign dec     = dec_q;
  assign upd_err = upd_err_q;

endmodule

// File: tb/tb_jtag_ir_param.sv
// tb/tb_jtag_ir_param.sv - self-checking bench for jtag_ir_param (strict and lenient instances)
module tb_jtag_ir_param;
  localparam int W = 4;
  localparam int N = 6;
  localparam int RST_OP = 1;

  logic TCLK = 1'b0;
  logic TRST, tlr, captureir, shiftir, updateir, TDI;
  logic       tdo_s, tdoen_s, err_s, tdo_l, tdoen_l, err_l;
  logic [W-1:0] inst_s, inst_l;
  logic [N:0]   dec_s, dec_l;

  always #5 TCLK = ~TCLK;

  jtag_ir_param #(.IR_WIDTH(W), .NUM_INST(N), .RESET_INST(RST_OP), .STRICT_LEN(1)) u_strict (
    .TCLK(TCLK), .TRST(TRST), .tlr(tlr), .captureir(captureir), .shiftir(shiftir),
    .updateir(updateir), .TDI(TDI), .TDO(tdo_s), .tdo_en(tdoen_s), .inst(inst_s),
    .dec(dec_s), .upd_err(err_s));

  jtag_ir_param #(.IR_WIDTH(W), .NUM_INST(N), .RESET_INST(RST_OP), .STRICT_LEN(0)) u_loose (
    .TCLK(TCLK), .TRST(TRST), .tlr(tlr), .captureir(captureir), .shiftir(shiftir),
    .updateir(updateir), .TDI(TDI), .TDO(tdo_l), .tdo_en(tdoen_l), .inst(inst_l),
    .dec(dec_l), .upd_err(err_l));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference state: register contents as plain integers, bits shifted counted up to W.
  int m_shreg, m_cnt, m_inst_s, m_inst_l, m_err_s, m_err_l;
  int pre_tdo;

  function automatic int exp_dec(input int op);
    return 1 << ((op < N) ? op : N);
  endfunction

  function automatic int resolve(input int op);
    return (op < N) ? op : (1 << W) - 1;
  endfunction

  task automatic model_reset();
    m_shreg = 0; m_cnt = 0; m_inst_s = RST_OP; m_inst_l = RST_OP; m_err_s = 0; m_err_l = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".inst_s"}, 32'(inst_s), 32'(m_inst_s));
    chk({tag, ".dec_s"},  32'(dec_s),  32'(exp_dec(m_inst_s)));
    chk({tag, ".err_s"},  32'(err_s),  32'(m_err_s));
    chk({tag, ".tdo_s"},  32'(tdo_s),  32'(m_shreg % 2));
    chk({tag, ".inst_l"}, 32'(inst_l), 32'(m_inst_l));
    chk({tag, ".dec_l"},  32'(dec_l),  32'(exp_dec(m_inst_l)));
    chk({tag, ".err_l"},  32'(err_l),  32'(m_err_l));
    chk({tag, ".tdo_l"},  32'(tdo_l),  32'(m_shreg % 2));
  endtask

  task automatic cycle(input string tag, input bit cap, input bit sh, input bit upd,
                       input bit tdi, input bit tl);
    int n_shreg, n_cnt;
    @(negedge TCLK);
    captureir = cap; shiftir = sh; updateir = upd; TDI = tdi; tlr = tl;
    #1;
    pre_tdo = int'(tdo_s);
    chk({tag, ".tdo_en"}, 32'(tdoen_s), 32'(sh));
    if (sh) chk({tag, ".pre_tdo"}, 32'(tdo_s), 32'(m_shreg % 2));
    m_err_s = 0; m_err_l = 0;
    if (tl) begin
      model_reset();
    end else begin
      n_shreg = m_shreg; n_cnt = m_cnt;
      if (cap) begin
        n_shreg = 1; n_cnt = 0;
      end else if (sh) begin
        n_shreg = m_shreg / 2 + int'(tdi) * (1 << (W - 1));
        n_cnt = (m_cnt + 1 > W) ? W : m_cnt + 1;
      end
      if (upd) begin
        if (m_cnt < W) m_err_s = 1;
        else begin
          m_inst_s = resolve(m_shreg);
          m_err_s = (m_shreg >= N) ? 1 : 0;
        end
        m_inst_l = resolve(m_shreg);
        m_err_l = (m_shreg >= N) ? 1 : 0;
      end
      m_shreg = n_shreg; m_cnt = n_cnt;
    end
    @(posedge TCLK);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 0, 0, 0, 0, 0);
  endtask

  task automatic load_op(input string tag, input int op);
    cycle(tag, 1, 0, 0, 0, 0);
    for (int i = 0; i < W; i++) cycle(tag, 0, 1, 0, bit'((op >> i) & 1), 0);
    cycle(tag, 0, 0, 1, 0, 0);
  endtask

  initial begin
    TRST = 1'b1; tlr = 0; captureir = 0; shiftir = 0; updateir = 0; TDI = 0;
    model_reset();
    #12;
    chk("rst.inst", 32'(inst_s), 32'h1);
    chk("rst.dec",  32'(dec_s),  32'h02);
    chk("rst.tdo",  32'(tdo_s),  32'h0);
    chk("rst.err",  32'(err_s),  32'h0);
    TRST = 1'b0;

    // Opcode 0011 shifted LSB-first; TDO must present the captured 01 pattern then zeros.
    cycle("op3.cap", 1, 0, 0, 0, 0);
    cycle("op3.sh0", 0, 1, 0, 1, 0); chk("op3.tdo0", 32'(pre_tdo), 32'd1);
    cycle("op3.sh1", 0, 1, 0, 1, 0); chk("op3.tdo1", 32'(pre_tdo), 32'd0);
    cycle("op3.sh2", 0, 1, 0, 0, 0); chk("op3.tdo2", 32'(pre_tdo), 32'd0);
    cycle("op3.sh3", 0, 1, 0, 0, 0); chk("op3.tdo3", 32'(pre_tdo), 32'd0);
    cycle("op3.upd", 0, 0, 1, 0, 0);
    chk("op3.inst", 32'(inst_s), 32'h3);
    chk("op3.dec",  32'(dec_s),  32'h08);
    chk("op3.err",  32'(err_s),  32'h0);

    // Short shift: strict rejects, lenient accepts 0100.
    cycle("short.cap", 1, 0, 0, 0, 0);
    cycle("short.sh0", 0, 1, 0, 1, 0);
    cycle("short.sh1", 0, 1, 0, 0, 0);
    cycle("short.upd", 0, 0, 1, 0, 0);
    chk("short.inst_s", 32'(inst_s), 32'h3);
    chk("short.err_s",  32'(err_s),  32'h1);
    chk("short.inst_l", 32'(inst_l), 32'h4);
    chk("short.err_l",  32'(err_l),  32'h0);
    idle("short.idle");
    chk("short.err_drop", 32'(err_s), 32'h0);

    // Overlong shift keeps the last four bits.
    cycle("long.cap", 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle("long.sh", 0, 1, 0, bit'(i % 2 == 0), 0);
    cycle("long.upd", 0, 0, 1, 0, 0);
    chk("long.inst", 32'(inst_s), 32'h5);

    load_op("illegal", 9);
    chk("illegal.inst", 32'(inst_s), 32'hF);
    chk("illegal.dec",  32'(dec_s),  32'h40);
    chk("illegal.err",  32'(err_s),  32'h1);

    load_op("pre_tlr", 3);
    cycle("tlr", 0, 0, 0, 0, 1);
    chk("tlr.inst", 32'(inst_s), 32'h1);

    // Asynchronous TRST in the middle of a shift.
    load_op("pre_trst", 2);
    cycle("trst.cap", 1, 0, 0, 0, 0);
    cycle("trst.sh0", 0, 1, 0, 1, 0);
    cycle("trst.sh1", 0, 1, 0, 0, 0);
    #2 TRST = 1'b1;
    #1;
    model_reset();
    chk("trst.inst", 32'(inst_s), 32'h1);
    chk("trst.dec",  32'(dec_s),  32'h02);
    chk("trst.tdo",  32'(tdo_s),  32'h0);
    chk("trst.err",  32'(err_s),  32'h0);
    @(negedge TCLK);
    shiftir = 0;
    TRST = 1'b0;
    cycle("trst.sh2", 0, 1, 0, 1, 0);
    cycle("trst.sh3", 0, 1, 0, 1, 0);
    cycle("trst.upd", 0, 0, 1, 0, 0);
    chk("trst.rej_inst", 32'(inst_s), 32'h1);
    chk("trst.rej_err",  32'(err_s),  32'h1);

    // Randomized control mixes, including overlapping capture/shift/update.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      cycle("rand", bit'(r < 10), bit'(r >= 5 && r < 75), bit'(r >= 70 && r < 90 || r >= 97),
            bit'($urandom_range(0, 1)), bit'(r == 96));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
